// File: rtl/dip_pkg.sv
// dip_pkg: shared constants and types for the DIP switch input path.
//   DIP_WIDTH          - width of the parallel DIP word
//   DIP_STABLE_DEFAULT - default number of identical frames needed to commit
//   evt_state_t        - encoding of the CPU-side change-event FSM
package dip_pkg;

  localparam int DIP_WIDTH          = 16;
  localparam int DIP_STABLE_DEFAULT = 4;

  typedef enum logic {
    EVT_IDLE    = 1'b0,
    EVT_PENDING = 1'b1
  } evt_state_t;

endpackage

// File: rtl/dip_sample_filter.sv
// dip_sample_filter: qualifies parallel DIP frames.
// Holds a candidate word and a saturating count of consecutive identical
// frames. On a strobe whose frame brings the count to STABLE_CNT with a
// candidate different from the committed word, commit pulses for that cycle.
//
// Ports:
//   i_CLK, i_RESET - clock, synchronous active-high reset
//   sample         - one-cycle strobe, dip holds a fresh frame
//   dip            - raw parallel frame
//   stable         - currently committed word (owned by the parent)
//   cand_next      - candidate value as of the end of this cycle
//   commit         - combinational pulse: parent should commit cand_next
import dip_pkg::*;

module dip_sample_filter #(
  parameter int WIDTH      = DIP_WIDTH,
  parameter int STABLE_CNT = DIP_STABLE_DEFAULT
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic             sample,
  input  logic [WIDTH-1:0] dip,
  input  logic [WIDTH-1:0] stable,
  output logic [WIDTH-1:0] cand_next,
  output logic             commit
);

  localparam int CNT_W = $clog2(STABLE_CNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CNT);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [WIDTH-1:0] cand;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;

  // Frames without a strobe are ignored entirely, whatever dip shows.
  always_comb begin
    cand_next = cand;
    cnt_next  = cnt;
    if (sample) begin
      if (dip == cand) begin
        // Saturate so a held value commits once and never wraps.
        cnt_next = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      end else begin
        cand_next = dip;
        cnt_next  = CNT_ONE;
      end
    end
  end

  // Once committed, cand equals stable, so a saturated count cannot re-fire.
  assign commit = sample && (cnt_next == CNT_MAX) && (cand_next != stable);

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      cand <= '0;
      cnt  <= '0;
    end else begin
      cand <= cand_next;
      cnt  <= cnt_next;
    end
  end

endmodule

// File: rtl/dip_debouncer.sv
// dip_debouncer: debounces the 16-bit DIP parallelizer word and reports
// committed changes to the CPU side.
//
// Ports:
//   i_CLK     - system clock
//   i_RESET   - synchronous active-high reset
//   i_DIP16   - raw parallel DIP word
//   i_Sample  - one-cycle strobe marking a freshly completed frame
//   i_Ack     - consumer acknowledge of a pending event
//   o_Stable  - last committed word
//   o_Changed - bits toggled by commits not yet acknowledged
//   o_Event   - a change is pending
//   o_Overrun - sticky: a commit landed while an event was already pending
//
// Handshake: o_Event acts as valid and stays high until the consumer
// returns i_Ack (ready) with o_Event high; the event clears the next cycle.
// i_Ack with no pending event is ignored. A commit arriving in the same
// cycle as the ack replaces the mask instead of merging into it.
import dip_pkg::*;

module dip_debouncer #(
  parameter int WIDTH      = DIP_WIDTH,
  parameter int STABLE_CNT = DIP_STABLE_DEFAULT
) (
  input  logic             i_CLK,
  input  logic             i_RESET,
  input  logic [WIDTH-1:0] i_DIP16,
  input  logic             i_Sample,
  input  logic             i_Ack,
  output logic [WIDTH-1:0] o_Stable,
  output logic [WIDTH-1:0] o_Changed,
  output logic             o_Event,
  output logic             o_Overrun
);

  evt_state_t       state;
  logic [WIDTH-1:0] cand_next;
  logic             commit;
  logic [WIDTH-1:0] delta;

  dip_sample_filter #(
    .WIDTH      (WIDTH),
    .STABLE_CNT (STABLE_CNT)
  ) u_filter (
    .i_CLK     (i_CLK),
    .i_RESET   (i_RESET),
    .sample    (i_Sample),
    .dip       (i_DIP16),
    .stable    (o_Stable),
    .cand_next (cand_next),
    .commit    (commit)
  );

  assign delta = cand_next ^ o_Stable;

  always_ff @(posedge i_CLK) begin
    if (i_RESET) begin
      state     <= EVT_IDLE;
      o_Stable  <= '0;
      o_Changed <= '0;
      o_Event   <= 1'b0;
      o_Overrun <= 1'b0;
    end else begin
      if (commit) begin
        o_Stable <= cand_next;
      end
      case (state)
        EVT_IDLE: begin
          if (commit) begin
            o_Changed <= delta;
            o_Event   <= 1'b1;
            state     <= EVT_PENDING;
          end
        end
        EVT_PENDING: begin
          if (i_Ack && commit) begin
            // The acknowledged mask is consumed; only the new change remains.
            o_Changed <= delta;
            o_Overrun <= 1'b0;
          end else if (i_Ack) begin
            o_Changed <= '0;
            o_Event   <= 1'b0;
            o_Overrun <= 1'b0;
            state     <= EVT_IDLE;
          end else if (commit) begin
            o_Changed <= o_Changed | delta;
            o_Overrun <= 1'b1;
          end
        end
        default: state <= EVT_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dip_debouncer.sv
module tb_dip_debouncer;

  logic        i_CLK;
  logic        i_RESET;
  logic [15:0] i_DIP16;
  logic        i_Sample;
  logic        i_Ack;
  logic [15:0] o_Stable;
  logic [15:0] o_Changed;
  logic        o_Event;
  logic        o_Overrun;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Observed tuple {o_Stable, o_Changed, o_Event, o_Overrun}
  logic [33:0] obs;
  assign obs = {o_Stable, o_Changed, o_Event, o_Overrun};

  dip_debouncer #(
    .WIDTH      (16),
    .STABLE_CNT (4)
  ) dut (
    .i_CLK     (i_CLK),
    .i_RESET   (i_RESET),
    .i_DIP16   (i_DIP16),
    .i_Sample  (i_Sample),
    .i_Ack     (i_Ack),
    .o_Stable  (o_Stable),
    .o_Changed (o_Changed),
    .o_Event   (o_Event),
    .o_Overrun (o_Overrun)
  );

  // Clock / reset
  initial i_CLK = 1'b0;
  always #5 i_CLK = ~i_CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got %0d/%0d checks passed so far", pass_cnt, total_cnt);
    $fatal(1, "watchdog");
  end

  // Driver tasks: inputs change on the falling edge, outputs are
  // inspected 1 time unit after the rising edge.
  task automatic do_reset();
    @(negedge i_CLK);
    i_RESET = 1'b1;
    @(posedge i_CLK);
    #1;
    i_RESET = 1'b0;
  endtask

  task automatic strobe(input logic [15:0] v, input logic ack);
    @(negedge i_CLK);
    i_DIP16  = v;
    i_Sample = 1'b1;
    i_Ack    = ack;
    @(posedge i_CLK);
    #1;
    i_Sample = 1'b0;
    i_Ack    = 1'b0;
  endtask

  task automatic gap();
    @(negedge i_CLK);
    i_DIP16  = 16'hFFFF;
    i_Sample = 1'b0;
    @(posedge i_CLK);
    #1;
  endtask

  task automatic ack_pulse();
    @(negedge i_CLK);
    i_Ack = 1'b1;
    @(posedge i_CLK);
    #1;
    i_Ack = 1'b0;
  endtask

  // Tests
  task automatic test_reset();
    logic [33:0] exp;
    @(negedge i_CLK);
    i_RESET  = 1'b1;
    i_Sample = 1'b1;
    i_Ack    = 1'b1;
    i_DIP16  = 16'h1234;
    repeat (2) @(posedge i_CLK);
    #1;
    exp = 34'h0;
    total_cnt++;
    if (obs !== exp) $display("FAIL reset_state: got %h expected %h", obs, exp);
    else pass_cnt++;
    i_RESET  = 1'b0;
    i_Sample = 1'b0;
    i_Ack    = 1'b0;
  endtask

  task automatic test_idle_zero();
    logic [33:0] exp;
    exp = 34'h0;
    for (int i = 0; i < 5; i++) begin
      strobe(16'h0000, 1'b0);
      total_cnt++;
      if (obs !== exp) $display("FAIL zero_strobe_%0d: got %h expected %h", i, obs, exp);
      else pass_cnt++;
    end
  endtask

  task automatic test_commit();
    logic [33:0] exp;
    for (int i = 0; i < 3; i++) begin
      strobe(16'h00A5, 1'b0);
      exp = 34'h0;
      total_cnt++;
      if (obs !== exp) $display("FAIL commit_early_%0d: got %h expected %h", i, obs, exp);
      else pass_cnt++;
    end
    strobe(16'h00A5, 1'b0);
    exp = {16'h00A5, 16'h00A5, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL commit_fourth: got %h expected %h", obs, exp);
    else pass_cnt++;
    // Saturated counter: the held value must not commit again.
    strobe(16'h00A5, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL commit_once: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic [15:0] seq [6];
    logic [33:0] exp;
    seq = '{16'h00A5, 16'h00A5, 16'h00A4, 16'h00A5, 16'h00A5, 16'h00A5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      strobe(seq[i], 1'b0);
      gap();
    end
    exp = 34'h0;
    total_cnt++;
    if (obs !== exp) $display("FAIL glitch_no_commit: got %h expected %h", obs, exp);
    else pass_cnt++;
    strobe(16'h00A5, 1'b0);
    exp = {16'h00A5, 16'h00A5, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL glitch_seventh: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_ack();
    logic [33:0] exp;
    ack_pulse();
    exp = {16'h00A5, 16'h0000, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL ack_clear: got %h expected %h", obs, exp);
    else pass_cnt++;
    ack_pulse();
    total_cnt++;
    if (obs !== exp) $display("FAIL ack_idle: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    logic [33:0] exp;
    do_reset();
    repeat (4) strobe(16'h00A5, 1'b0);
    exp = {16'h00A5, 16'h00A5, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL ovr_pending: got %h expected %h", obs, exp);
    else pass_cnt++;
    repeat (3) strobe(16'h80A5, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL ovr_early: got %h expected %h", obs, exp);
    else pass_cnt++;
    strobe(16'h80A5, 1'b0);
    exp = {16'h80A5, 16'h80A5, 1'b1, 1'b1};
    total_cnt++;
    if (obs !== exp) $display("FAIL ovr_merge: got %h expected %h", obs, exp);
    else pass_cnt++;
    ack_pulse();
    exp = {16'h80A5, 16'h0000, 1'b0, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL ovr_ack: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [33:0] exp;
    do_reset();
    repeat (4) strobe(16'h0005, 1'b0);
    exp = {16'h0005, 16'h0005, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_first: got %h expected %h", obs, exp);
    else pass_cnt++;
    repeat (4) strobe(16'h80A5, 1'b0);
    exp = {16'h80A5, 16'h80A5, 1'b1, 1'b1};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_overrun: got %h expected %h", obs, exp);
    else pass_cnt++;
    repeat (3) strobe(16'h80A4, 1'b0);
    strobe(16'h80A4, 1'b1);
    exp = {16'h80A4, 16'h0001, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL b2b_ack_commit: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  task automatic test_reset_midcount();
    logic [33:0] exp;
    repeat (3) strobe(16'h1234, 1'b0);
    do_reset();
    exp = 34'h0;
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_pending: got %h expected %h", obs, exp);
    else pass_cnt++;
    strobe(16'h1234, 1'b0);
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_count_cleared: got %h expected %h", obs, exp);
    else pass_cnt++;
    repeat (3) strobe(16'h1234, 1'b0);
    exp = {16'h1234, 16'h1234, 1'b1, 1'b0};
    total_cnt++;
    if (obs !== exp) $display("FAIL rst_recount: got %h expected %h", obs, exp);
    else pass_cnt++;
  endtask

  initial begin
    i_RESET  = 1'b0;
    i_DIP16  = 16'h0000;
    i_Sample = 1'b0;
    i_Ack    = 1'b0;
    test_reset();
    test_idle_zero();
    test_commit();
    test_glitch();
    test_ack();
    test_overrun();
    test_back_to_back();
    test_reset_midcount();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
